hazard_stall_controller: RTL
============================

# hazard_stall_controller

Generates the stall and flush controls consumed by the IF/ID pipeline register and the PC: `WriteInstruction` (hold), `Flush` (squash), plus the PC write enable and the ID/EX bubble select. It sits beside the ID stage. It compares the source registers of the instruction in ID against destinations in ID/EX and EX/MEM, and a small FSM holds multi-cycle stalls for branches resolved in ID. It is the driving end of the IF/ID hold/flush interface.

## Interface
- `REG_W`, default 5, register-address width.
- `CNT_W`, default 32, statistics counter width (used only with `HAZARD_STATS_EN`).

Ports:
- `Clk` in 1: single clock; state updates on posedge.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `IFID_Rs`, `IFID_Rt` in `REG_W`: source registers of the instruction in ID.
- `IFID_UsesRs`, `IFID_UsesRt` in 1: the instruction actually reads that source.
- `IFID_IsBranch` in 1: conditional branch, compared in ID.
- `IFID_IsJump` in 1: j/jal/jr in ID.
- `BranchTaken` in 1: ID comparator result; meaningful only with `IFID_IsBranch`.
- `IDEX_RegWrite`, `IDEX_MemRead` in 1; `IDEX_Rd` in `REG_W`: the ID/EX destination, taken after the RegDst mux.
- `EXMEM_MemRead` in 1; `EXMEM_Rd` in `REG_W`.
- `PCWrite` out 1: 1 means the PC updates.
- `WriteInstruction` out 1: 1 means IF/ID holds its contents.
- `Flush` out 1: 1 means the IF/ID instruction output is zeroed.
- `IDEX_Bubble` out 1: 1 means the ID/EX control word is zeroed.
- `StallCount`, `FlushCount` out `CNT_W`: present only with `HAZARD_STATS_EN`.

## Operation
- A match requires a nonzero destination register that equals a source register whose `Uses*` flag is set. Register 0 never matches.
- Hazard classes, evaluated in state RUN. The needed stall count N is the maximum over all matching classes:
  - Load-use: `IDEX_MemRead` and a match on `IDEX_Rd`. N=1.
  - Branch on ALU result: `IFID_IsBranch`, `IDEX_RegWrite`, not `IDEX_MemRead`, and a match on `IDEX_Rd`. N=1.
  - Branch on load in ID/EX: `IFID_IsBranch`, `IDEX_MemRead`, and a match on `IDEX_Rd`. N=2.
  - Branch on load in EX/MEM: `IFID_IsBranch`, `EXMEM_MemRead`, and a match on `EXMEM_Rd`. N=1.
- FSM state is RUN or STALL, with a 2-bit `remain` counter.
- In RUN with N>0: the unit stalls this cycle. If N=2 it moves to STALL with `remain`=1; otherwise it stays in RUN.
- In STALL: the unit stalls unconditionally and ignores hazard inputs. It decrements `remain` and returns to RUN when `remain` reaches 0.
- A stall cycle drives `PCWrite`=0, `WriteInstruction`=1, `IDEX_Bubble`=1 and `Flush`=0.
- In RUN with N=0 and either `IFID_IsJump`, or `IFID_IsBranch` with `BranchTaken`: the unit drives `Flush`=1 and `PCWrite`=1 for that cycle.
- The default (RUN, no event) is `PCWrite`=1 and `WriteInstruction`=0, with `Flush` and `IDEX_Bubble` both 0.
- A stall has priority over a flush. A branch is resolved only in the cycle where no stall is required.

## Timing
- Outputs are Mealy: combinational from the state and current inputs. They are valid before the posedge at which IF/ID and the PC sample them.
- Latency from hazard to control output is 0 cycles. Total stall bubbles per hazard are 1 or 2.
- While `Rst_n` is 0:
  - `PCWrite`=0, `WriteInstruction`=1, `Flush`=1, `IDEX_Bubble`=1.
  - The state is RUN, `remain`=0, and the counters are 0.
- Reset asserted during STALL aborts the stall immediately. After deassertion the unit resumes in RUN.
- If the instruction in ID changes mid-STALL, the stall still completes. The upstream logic must not change IF/ID while the hold is asserted.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `StallCount` increments on every posedge with a stall cycle.
  - `FlushCount` increments on every posedge with `Flush`=1 outside reset.
  - Both wrap modulo 2^`CNT_W`.
- Undefined: both ports and their registers are absent. Control behaviour is identical either way.

## Structure
- `hazard_pkg` holds:
  - the state enum `hz_state_t` {`HZ_RUN`, `HZ_STALL`};
  - the constants `HZ_N_LOADUSE`=1, `HZ_N_BR_ALU`=1, `HZ_N_BR_LOAD_EX`=2 and `HZ_N_BR_LOAD_MEM`=1;
  - `REG_ZERO`=0.
- Sub-module `hazard_detect`: a purely combinational block that computes N from the register fields. The top level keeps the FSM, the output decode and the counters.

## Test plan
- Load-use: ID/EX is `lw` with `IDEX_Rd`=8 and ID reads Rs=8 -> exactly one cycle of `PCWrite`=0, `WriteInstruction`=1, `IDEX_Bubble`=1, then the default outputs.
- Branch on a load in ID/EX: `IDEX_Rd`=9 with `MemRead`, ID is `beq` reading Rt=9 -> two consecutive stall cycles, even though the ID/EX inputs become a bubble after cycle 1.
- Taken branch with no hazard: `IFID_IsBranch`=1, `BranchTaken`=1 -> `Flush`=1 and `PCWrite`=1 for one cycle. With `IFID_IsJump` instead, the response is the same.
- Register 0: `IDEX_MemRead`=1 with `IDEX_Rd`=0 and ID reading Rs=0 -> no stall, default outputs.
- Stall versus flush: taken branch with an ALU hazard on `IDEX_Rd`=4 -> cycle 1 stalls with `Flush`=0; in cycle 2 the hazard is cleared and the unit drives `Flush`=1.
- Reset in STALL: assert `Rst_n`=0 during the first stall cycle of a 2-cycle stall -> the outputs immediately take their reset values; after release, the default outputs appear and there is no residual stall. With `HAZARD_STATS_EN`, `StallCount` reads 0.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the IF/ID hazard stall controller.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
package hazard_pkg;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_t;

  localparam logic [1:0] HZ_N_LOADUSE     = 2'd1;
  localparam logic [1:0] HZ_N_BR_ALU      = 2'd1;
  localparam logic [1:0] HZ_N_BR_LOAD_EX  = 2'd2;
  localparam logic [1:0] HZ_N_BR_LOAD_MEM = 2'd1;

  localparam int unsigned REG_ZERO = 32'd0;

  function automatic logic [1:0] hz_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// IF/ID hold/flush control bundle; the stall controller is the master (driving) end.
interface hazard_stall_controller_if;

  logic PCWrite;
  logic WriteInstruction;
  logic Flush;
  logic IDEX_Bubble;

  modport master (
    output PCWrite,
    output WriteInstruction,
    output Flush,
    output IDEX_Bubble
  );

  modport slave (
    input PCWrite,
    input WriteInstruction,
    input Flush,
    input IDEX_Bubble
  );

endinterface

// File: rtl/hazard_stall_controller_detect.sv
// Combinational hazard classifier: returns the number of stall cycles the
// instruction in ID needs (largest over all matching hazard classes).
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRs,
  input  logic             IFID_UsesRt,
  input  logic             IFID_IsBranch,
  input  logic             IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             EXMEM_MemRead,
  input  logic [REG_W-1:0] EXMEM_Rd,
  output logic [1:0]       stall_need
);

  // Register 0 is hard-wired, so a write to it can never create a hazard.
  function automatic logic dest_hits(input logic [REG_W-1:0] dst);
    return (dst != REG_W'(REG_ZERO)) &&
           ((IFID_UsesRs && (dst == IFID_Rs)) || (IFID_UsesRt && (dst == IFID_Rt)));
  endfunction

  logic       idex_hit_s;
  logic       exmem_hit_s;
  logic [1:0] n_loaduse_s;
  logic [1:0] n_br_alu_s;
  logic [1:0] n_br_load_ex_s;
  logic [1:0] n_br_load_mem_s;

  assign idex_hit_s  = dest_hits(IDEX_Rd);
  assign exmem_hit_s = dest_hits(EXMEM_Rd);

  assign n_loaduse_s     = (IDEX_MemRead && idex_hit_s) ? HZ_N_LOADUSE : 2'd0;
  assign n_br_alu_s      = (IFID_IsBranch && IDEX_RegWrite && !IDEX_MemRead && idex_hit_s)
                           ? HZ_N_BR_ALU : 2'd0;
  assign n_br_load_ex_s  = (IFID_IsBranch && IDEX_MemRead && idex_hit_s) ? HZ_N_BR_LOAD_EX : 2'd0;
  assign n_br_load_mem_s = (IFID_IsBranch && EXMEM_MemRead && exmem_hit_s) ? HZ_N_BR_LOAD_MEM : 2'd0;

  assign stall_need = hz_max(hz_max(n_loaduse_s, n_br_alu_s),
                             hz_max(n_br_load_ex_s, n_br_load_mem_s));

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush controller beside the ID stage: FSM for multi-cycle branch stalls,
// Mealy output decode, and optional StallCount/FlushCount (HAZARD_STATS_EN).
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRs,
  input  logic             IFID_UsesRt,
  input  logic             IFID_IsBranch,
  input  logic             IFID_IsJump,
  input  logic             BranchTaken,
  input  logic             IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             EXMEM_MemRead,
  input  logic [REG_W-1:0] EXMEM_Rd,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
`endif
  hazard_stall_controller_if.master ctrl
);

  hz_state_t  state_r;
  hz_state_t  state_nxt_s;
  logic [1:0] remain_r;
  logic [1:0] remain_nxt_s;
  logic [1:0] need_s;
  logic       stall_s;
  logic       flush_s;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .IFID_Rs       (IFID_Rs),
    .IFID_Rt       (IFID_Rt),
    .IFID_UsesRs   (IFID_UsesRs),
    .IFID_UsesRt   (IFID_UsesRt),
    .IFID_IsBranch (IFID_IsBranch),
    .IDEX_RegWrite (IDEX_RegWrite),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_Rd       (IDEX_Rd),
    .EXMEM_MemRead (EXMEM_MemRead),
    .EXMEM_Rd      (EXMEM_Rd),
    .stall_need    (need_s)
  );

  // Next-state and stall/flush decision; STALL ignores the hazard inputs entirely.
  always_comb begin
    state_nxt_s  = state_r;
    remain_nxt_s = remain_r;
    stall_s      = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      HZ_RUN: begin
        if (need_s != 2'd0) begin
          stall_s = 1'b1;
          if (need_s == HZ_N_BR_LOAD_EX) begin
            state_nxt_s  = HZ_STALL;
            remain_nxt_s = need_s - 2'd1;
          end else begin
            state_nxt_s  = HZ_RUN;
            remain_nxt_s = 2'd0;
          end
        end else begin
          flush_s = IFID_IsJump || (IFID_IsBranch && BranchTaken);
        end
      end
      HZ_STALL: begin
        stall_s      = 1'b1;
        remain_nxt_s = remain_r - 2'd1;
        if (remain_nxt_s == 2'd0) begin
          state_nxt_s = HZ_RUN;
        end else begin
          state_nxt_s = HZ_STALL;
        end
      end
      default: begin
        state_nxt_s  = HZ_RUN;
        remain_nxt_s = 2'd0;
      end
    endcase
  end

  // Output decode; reset forces the safe hold/squash pattern combinationally.
  always_comb begin
    ctrl.PCWrite          = 1'b1;
    ctrl.WriteInstruction = 1'b0;
    ctrl.Flush            = 1'b0;
    ctrl.IDEX_Bubble      = 1'b0;
    if (!Rst_n) begin
      ctrl.PCWrite          = 1'b0;
      ctrl.WriteInstruction = 1'b1;
      ctrl.Flush            = 1'b1;
      ctrl.IDEX_Bubble      = 1'b1;
    end else if (stall_s) begin
      ctrl.PCWrite          = 1'b0;
      ctrl.WriteInstruction = 1'b1;
      ctrl.Flush            = 1'b0;
      ctrl.IDEX_Bubble      = 1'b1;
    end else begin
      ctrl.PCWrite          = 1'b1;
      ctrl.WriteInstruction = 1'b0;
      ctrl.Flush            = flush_s;
      ctrl.IDEX_Bubble      = 1'b0;
    end
  end

  // FSM state and remaining-stall counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r  <= HZ_RUN;
      remain_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      remain_r <= remain_nxt_s;
    end
  end

`ifdef HAZARD_STATS_EN
  // Free-running statistics, wrapping at 2^CNT_W.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount <= {CNT_W{1'b0}};
      FlushCount <= {CNT_W{1'b0}};
    end else begin
      StallCount <= stall_s ? StallCount + {{(CNT_W-1){1'b0}}, 1'b1} : StallCount;
      FlushCount <= flush_s ? FlushCount + {{(CNT_W-1){1'b0}}, 1'b1} : FlushCount;
    end
  end
`endif

endmodule
